wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback stage directly downstream of the execute stage.
- Latches the execute result (valid, rd number, write-enable, data) into a stage register and commits it to the architectural register file one cycle later.
- Serves two combinational read ports to decode, with write-through bypass of the pending commit.
- Provides a halt/drain handshake and a retired-instruction counter for debug.

Parameters:
WORD, 32, data word width
W_RD, 5, register number width
NREGS, 32, number of architectural registers (must equal 2**W_RD)
W_CNT, 32, retired-instruction counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
v_i  input  1  execute result valid
stall_o  output  1  back-pressure to execute; high = do not advance
rd_num_i  input  W_RD  destination register number
wb_i  input  1  result is to be written to rd
rd_data_i  input  WORD  result data
ra_num_i  input  W_RD  read port A register number (from decode)
ra_data_o  output  WORD  read port A data
rb_num_i  input  W_RD  read port B register number
rb_data_o  output  WORD  read port B data
halt_req_i  input  1  debug halt request, level
halted_o  output  1  stage drained and halted
retired_o  output  W_CNT  count of committed valid instructions

Behaviour:
- Reset (async, rst=1):
  - v_r, wb_r, rd_num_r and data_r clear to 0.
  - All NREGS registers clear to 0.
  - FSM goes to RUN; retired_o=0, halted_o=0, stall_o=0.
  - Reset mid-drain abandons the pending commit.
- FSM states: RUN, DRAIN, HALTED. State is registered; stall_o = (state != RUN), decoded from the registered state only.
- RUN:
  - Every cycle, v_r<=v_i, rd_num_r<=rd_num_i, wb_r<=wb_i, data_r<=rd_data_i. Invalid inputs load v_r=0.
  - If halt_req_i=1 -> DRAIN. The input offered in that same cycle is still accepted.
- DRAIN:
  - Stage register holds its content and accepts no new input.
  - The pending entry commits this cycle; v_r clears at the edge; next state HALTED.
- HALTED:
  - halted_o=1, stall_o=1, v_r=0.
  - halt_req_i=0 -> RUN; stall_o drops the cycle after the deassertion is sampled.
- Commit (any state):
  - When v_r=1 at a rising edge, retired_o increments by 1. It wraps modulo 2**W_CNT with no saturation.
  - When v_r & wb_r & (rd_num_r != 0), regs[rd_num_r] <= data_r.
  - Commit latency from acceptance: exactly 1 cycle, i.e. the register file holds the value 2 edges after the input is presented.
- Register 0 is hardwired zero: writes to it are discarded and reads return 0. Entries with wb_r=0 still count as retired.
- Read ports (combinational):
  - ra_data_o = 0 if ra_num_i==0.
  - Else data_r if (v_r & wb_r & rd_num_r==ra_num_i).
  - Else regs[ra_num_i].
  - Same rules apply to port B. Both ports may address the same register.
- Simultaneous events:
  - A commit and a bypass read of the same register in one cycle return data_r.
  - Back-to-back writes to the same register: the later one wins; bypass always shows the newest pending entry.
- Ordering: no entry is ever lost or duplicated across RUN->DRAIN->HALTED->RUN.

Test Plan:
- Reset then read all registers -> every ra_data_o/rb_data_o = 0, retired_o=0, stall_o=0, halted_o=0.
- Present v_i=1, wb_i=1, rd=5, data=0xDEADBEEF at cycle 0 with ra_num_i=5 -> ra_data_o=0xDEADBEEF via bypass in cycle 1, from the file in cycle 2+; retired_o=1.
- Write rd=0 with data 0x12345678 -> reads of r0 stay 0; retired_o increments.
- Back-to-back writes r7=1, r7=2, then rb_num_i=7 -> rb_data_o=1 in cycle 1, then 2 from cycle 2 onward.
- Assert halt_req_i in the same cycle as a valid write r3=0xA5 -> accepted; stall_o=1 next cycle; halted_o=1 the cycle after; r3=0xA5. Deassert halt_req_i -> stall_o=0 the following cycle.
- Assert rst mid-DRAIN with a pending write -> all outputs 0 immediately, the write is not committed; preload retired_o near 2**W_CNT-1 (small W_CNT build) -> wraps to 0.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage register, architectural register file, halt/drain control
//
// Purpose:
//   Captures the execute-stage result into a one-entry stage register and commits
//   it to the architectural register file on the following rising edge. Two
//   combinational read ports serve decode, with write-through bypass of the
//   pending (not yet committed) entry. A level halt request drains the stage and
//   parks it; a free-running counter reports committed (retired) instructions.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   v_i         execute result valid
//   stall_o     back-pressure to execute, high while not in RUN
//   rd_num_i    destination register number
//   wb_i        result writes rd
//   rd_data_i   result data
//   ra_num_i    read port A register number
//   ra_data_o   read port A data
//   rb_num_i    read port B register number
//   rb_data_o   read port B data
//   halt_req_i  debug halt request (level)
//   halted_o    stage drained and halted
//   retired_o   count of committed valid entries, wraps

module wb_regfile #(
  parameter int WORD  = 32,
  parameter int W_RD  = 5,
  parameter int NREGS = 32,
  parameter int W_CNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [W_RD-1:0]  rd_num_i,
  input  logic             wb_i,
  input  logic [WORD-1:0]  rd_data_i,
  input  logic [W_RD-1:0]  ra_num_i,
  output logic [WORD-1:0]  ra_data_o,
  input  logic [W_RD-1:0]  rb_num_i,
  output logic [WORD-1:0]  rb_data_o,
  input  logic             halt_req_i,
  output logic             halted_o,
  output logic [W_CNT-1:0] retired_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Stage register: the entry accepted last cycle, committed on the next edge.
  logic            v_r;
  logic            wb_r;
  logic [W_RD-1:0] rd_num_r;
  logic [WORD-1:0] data_r;

  logic [WORD-1:0]  regs [NREGS];
  logic [W_CNT-1:0] retired_r;

  logic load_stage;
  logic commit_wr;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_stage = 1'b0;
    case (state)
      RUN: begin
        // The input offered alongside the halt request is still taken.
        load_stage = 1'b1;
        if (halt_req_i) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = HALTED;
      end
      HALTED: begin
        if (!halt_req_i) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Decoded from the registered state only, so execute never sees a
  // combinational path from halt_req_i.
  assign stall_o  = (state != RUN);
  assign halted_o = (state == HALTED);

  // ---------------------------------------------------------------------------
  // Stage register
  // ---------------------------------------------------------------------------
  // Outside RUN the payload fields hold and only the valid bit clears, so the
  // entry pending on entry to DRAIN commits exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r      <= 1'b0;
      wb_r     <= 1'b0;
      rd_num_r <= '0;
      data_r   <= '0;
    end else if (load_stage) begin
      v_r      <= v_i;
      wb_r     <= wb_i;
      rd_num_r <= rd_num_i;
      data_r   <= rd_data_i;
    end else begin
      v_r      <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit
  // ---------------------------------------------------------------------------
  // r0 is never written; its storage stays at the reset value and reads of it
  // are forced to zero at the ports anyway.
  assign commit_wr = v_r & wb_r & (rd_num_r != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit_wr) begin
      regs[rd_num_r] <= data_r;
    end
  end

  // Every valid entry retires, including ones that do not write rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_r <= '0;
    end else if (v_r) begin
      retired_r <= retired_r + 1'b1;
    end
  end

  assign retired_o = retired_r;

  // ---------------------------------------------------------------------------
  // Read ports with bypass of the pending entry
  // ---------------------------------------------------------------------------
  // The pending entry is newer than anything in the file, so it takes priority;
  // on a commit cycle it is also the value about to land, so both agree.
  always_comb begin
    ra_data_o = regs[ra_num_i];
    if (ra_num_i == '0) begin
      ra_data_o = '0;
    end else if (v_r && wb_r && (rd_num_r == ra_num_i)) begin
      ra_data_o = data_r;
    end
  end

  always_comb begin
    rb_data_o = regs[rb_num_i];
    if (rb_num_i == '0) begin
      rb_data_o = '0;
    end else if (v_r && wb_r && (rd_num_r == rb_num_i)) begin
      rb_data_o = data_r;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile

module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [4:0]  rd_num_i = 5'd0;
  logic [31:0] rd_data_i = 32'd0;
  logic [4:0]  ra_num_i = 5'd0;
  logic [4:0]  rb_num_i = 5'd0;
  logic        halt_req_i = 1'b0;

  logic        stall_o, halted_o;
  logic [31:0] ra_data_o, rb_data_o, retired_o;

  logic        s_stall, s_halted;
  logic [31:0] s_ra, s_rb;
  logic [2:0]  s_retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile #(.WORD(32), .W_RD(5), .NREGS(32), .W_CNT(32)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o),
    .rd_num_i(rd_num_i), .wb_i(wb_i), .rd_data_i(rd_data_i),
    .ra_num_i(ra_num_i), .ra_data_o(ra_data_o),
    .rb_num_i(rb_num_i), .rb_data_o(rb_data_o),
    .halt_req_i(halt_req_i), .halted_o(halted_o), .retired_o(retired_o)
  );

  // Narrow-counter build to exercise wraparound quickly.
  wb_regfile #(.WORD(32), .W_RD(5), .NREGS(32), .W_CNT(3)) dut_small (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(s_stall),
    .rd_num_i(rd_num_i), .wb_i(wb_i), .rd_data_i(rd_data_i),
    .ra_num_i(ra_num_i), .ra_data_o(s_ra),
    .rb_num_i(rb_num_i), .rb_data_o(s_rb),
    .halt_req_i(halt_req_i), .halted_o(s_halted), .retired_o(s_retired)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a pending-entry slot in front of an array, plus two flags
  // describing whether execute is being held off and whether the drain is done.
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [32];
  bit          m_pv, m_pwb;
  logic [4:0]  m_prd;
  logic [31:0] m_pdata;
  bit          m_stall, m_halted;
  logic [31:0] m_ret;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pv = 0; m_pwb = 0; m_prd = 5'd0; m_pdata = 32'd0;
    m_stall = 0; m_halted = 0; m_ret = 32'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (m_pv && m_pwb && m_prd == r) return m_pdata;
    return m_regs[r];
  endfunction

  // One rising edge with the currently driven inputs.
  task automatic m_edge();
    if (m_pv) begin
      m_ret = m_ret + 32'd1;
      if (m_pwb && m_prd != 5'd0) m_regs[m_prd] = m_pdata;
    end
    if (!m_stall) begin
      m_pv = v_i; m_pwb = wb_i; m_prd = rd_num_i; m_pdata = rd_data_i;
      if (halt_req_i) m_stall = 1;
    end else if (!m_halted) begin
      m_pv = 0;
      m_halted = 1;
    end else begin
      m_pv = 0;
      if (!halt_req_i) begin
        m_stall = 0;
        m_halted = 0;
      end
    end
  endtask

  task automatic idle_inputs();
    v_i = 1'b0; wb_i = 1'b0; rd_num_i = 5'd0; rd_data_i = 32'd0;
    ra_num_i = 5'd0; rb_num_i = 5'd0; halt_req_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        v, wb, halt;
    logic [4:0]  rd, ra, rb;
    logic [31:0] data;
    logic [31:0] e_ra, e_rb;
    logic        e_stall, e_halted;
    logic [31:0] e_ret;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic wb, input logic [4:0] rd,
                              input logic [31:0] data, input logic halt,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [31:0] e_ra, input logic [31:0] e_rb,
                              input logic e_stall, input logic e_halted,
                              input logic [31:0] e_ret);
    vec_t t;
    t.v = v; t.wb = wb; t.rd = rd; t.data = data; t.halt = halt;
    t.ra = ra; t.rb = rb; t.e_ra = e_ra; t.e_rb = e_rb;
    t.e_stall = e_stall; t.e_halted = e_halted; t.e_ret = e_ret;
    return t;
  endfunction

  vec_t tbl [14];

  initial begin
    //             v     wb    rd     data           halt  ra     rb     e_ra           e_rb           stl   hlt   ret
    tbl[0]  = mk(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 32'd0);
    tbl[1]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    tbl[2]  = mk(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'd1);
    tbl[3]  = mk(1'b1, 1'b1, 5'd7, 32'h1,        1'b0, 5'd0, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0, 32'd1);
    tbl[4]  = mk(1'b1, 1'b1, 5'd7, 32'h2,        1'b0, 5'd0, 5'd7, 32'h0,        32'h1,        1'b0, 1'b0, 32'd2);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h2,        1'b0, 1'b0, 32'd3);
    tbl[6]  = mk(1'b1, 1'b0, 5'd9, 32'hFFFF,     1'b0, 5'd9, 5'd7, 32'h0,        32'h2,        1'b0, 1'b0, 32'd4);
    tbl[7]  = mk(1'b1, 1'b1, 5'd3, 32'hA5,       1'b1, 5'd9, 5'd3, 32'h0,        32'h0,        1'b0, 1'b0, 32'd4);
    tbl[8]  = mk(1'b1, 1'b1, 5'd3, 32'hBAD,      1'b1, 5'd3, 5'd9, 32'hA5,       32'h0,        1'b1, 1'b0, 32'd5);
    tbl[9]  = mk(1'b1, 1'b1, 5'd3, 32'hBAD,      1'b1, 5'd3, 5'd3, 32'hA5,       32'hA5,       1'b1, 1'b1, 32'd6);
    tbl[10] = mk(1'b1, 1'b1, 5'd3, 32'hBAD,      1'b0, 5'd3, 5'd0, 32'hA5,       32'h0,        1'b1, 1'b1, 32'd6);
    tbl[11] = mk(1'b1, 1'b1, 5'd4, 32'h44,       1'b0, 5'd3, 5'd4, 32'hA5,       32'h0,        1'b0, 1'b0, 32'd6);
    tbl[12] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd3, 32'h44,       32'hA5,       1'b0, 1'b0, 32'd6);
    tbl[13] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd3, 32'h44,       32'hA5,       1'b0, 1'b0, 32'd7);
  end

  initial begin
    m_reset();
    idle_inputs();

    // Reset state: every register reads zero on both ports.
    do_reset();
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      ra_num_i = 5'(r);
      rb_num_i = 5'(31 - r);
      #1;
      check32($sformatf("reset ra r%0d", r), ra_data_o, 32'd0);
      check32($sformatf("reset rb r%0d", 31 - r), rb_data_o, 32'd0);
    end
    check1("reset stall", stall_o, 1'b0);
    check1("reset halted", halted_o, 1'b0);
    check32("reset retired", retired_o, 32'd0);

    // Directed table: bypass, r0, back-to-back, halt/drain/resume.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      v_i = tbl[i].v; wb_i = tbl[i].wb; rd_num_i = tbl[i].rd; rd_data_i = tbl[i].data;
      halt_req_i = tbl[i].halt; ra_num_i = tbl[i].ra; rb_num_i = tbl[i].rb;
      #1;
      check32($sformatf("vec%0d ra", i), ra_data_o, tbl[i].e_ra);
      check32($sformatf("vec%0d rb", i), rb_data_o, tbl[i].e_rb);
      check1($sformatf("vec%0d stall", i), stall_o, tbl[i].e_stall);
      check1($sformatf("vec%0d halted", i), halted_o, tbl[i].e_halted);
      check32($sformatf("vec%0d retired", i), retired_o, tbl[i].e_ret);
    end

    // Randomized traffic against the model, with halt requests sprinkled in.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      v_i       = 1'($urandom_range(0, 1));
      wb_i      = ($urandom_range(0, 3) != 0);
      rd_num_i  = 5'($urandom_range(0, 7));
      rd_data_i = $urandom;
      ra_num_i  = 5'($urandom_range(0, 7));
      rb_num_i  = ($urandom_range(0, 3) == 0) ? ra_num_i : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) halt_req_i = ~halt_req_i;
      #1;
      check32($sformatf("rnd%0d ra", n), ra_data_o, m_read(ra_num_i));
      check32($sformatf("rnd%0d rb", n), rb_data_o, m_read(rb_num_i));
      check1($sformatf("rnd%0d stall", n), stall_o, m_stall);
      check1($sformatf("rnd%0d halted", n), halted_o, m_halted);
      check32($sformatf("rnd%0d retired", n), retired_o, m_ret);
      check32($sformatf("rnd%0d retired_w3", n), {29'd0, s_retired}, {29'd0, m_ret[2:0]});
      m_edge();
    end

    // Counter wrap on the 3-bit build: 8 commits -> 0, 9 commits -> 1.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      v_i = 1'b1; wb_i = 1'b1; rd_num_i = 5'd1; rd_data_i = 32'(k);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check32("wrap retired 8", retired_o, 32'd8);
    check32("wrap small at 8", {29'd0, s_retired}, 32'd0);
    @(negedge clk);
    ra_num_i = 5'd1;
    #1;
    check32("wrap retired 9", retired_o, 32'd9);
    check32("wrap small at 9", {29'd0, s_retired}, 32'd1);
    check32("wrap last write r1", ra_data_o, 32'd8);

    // Reset during DRAIN with a pending write: nothing lands.
    @(negedge clk);
    v_i = 1'b1; wb_i = 1'b1; rd_num_i = 5'd12; rd_data_i = 32'hCAFE;
    halt_req_i = 1'b1; ra_num_i = 5'd12;
    @(negedge clk);
    v_i = 1'b0;
    #1;
    check1("drain stall", stall_o, 1'b1);
    check32("drain bypass", ra_data_o, 32'hCAFE);
    rst = 1'b1;
    #1;
    check1("rst drain stall", stall_o, 1'b0);
    check1("rst drain halted", halted_o, 1'b0);
    check32("rst drain retired", retired_o, 32'd0);
    check32("rst drain r12", ra_data_o, 32'd0);
    ra_num_i = 5'd1;
    #1;
    check32("rst drain r1", ra_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    halt_req_i = 1'b0;
    @(negedge clk);
    ra_num_i = 5'd12;
    #1;
    check32("post rst r12", ra_data_o, 32'd0);
    check32("post rst retired", retired_o, 32'd0);
    check1("post rst stall", stall_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
